// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package hazard_pkg;

   localparam int ST_W     = 3;
   localparam int NSRC_DEF = 2;

   typedef logic [ST_W-1:0] stage_idx_t;

   // Source 1 (DCache) sits at stage 2; source 0 (ICache) is always stage 0.
   localparam logic [NSRC_DEF*ST_W-1:0] SRC_STAGE_DEF = {3'd2, 3'd0};

   localparam int SRC_ICACHE = 0;
   localparam int SRC_DCACHE = 1;

   typedef enum logic {
      KILL_IDLE = 1'b0,
      KILL_PEND = 1'b1
   } kill_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline and the hazard controller.
interface pipe_hazard_ctrl_if #(
   parameter int NSTAGE = 5,
   parameter int NSRC   = 2,
   parameter int CNT_W  = 32
);
   logic [NSRC-1:0]   src_valid;
   logic [NSRC-1:0]   src_ready;
   logic              redirect;
   logic              redirect_ack;
   logic              pc_stall;
   logic [NSTAGE-1:0] stage_stall;
   logic [NSTAGE-1:0] stage_flush;
   logic [CNT_W-1:0]  stall_cycles;
   logic              watchdog;
   logic              wd_clear;

   modport master (
      output src_valid, src_ready, redirect, wd_clear,
      input  redirect_ack, pc_stall, stage_stall, stage_flush, stall_cycles, watchdog
   );

   modport slave (
      input  src_valid, src_ready, redirect, wd_clear,
      output redirect_ack, pc_stall, stage_stall, stage_flush, stall_cycles, watchdog
   );
endinterface

// File: rtl/pipe_hazard_ctrl_stall_cnt.sv
// Saturating stall-cycle counter plus busy-run watchdog.
module hazard_stall_cnt #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             busy_i,
   input  logic             wd_clear_i,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic             watchdog_o
);

   localparam int RUN_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [RUN_W-1:0] RUN_TOP = RUN_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] stall_q, stall_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             wd_q, wd_d;

   // run_q counts down the busy cycles still allowed; RUN_TOP means an empty run.
   always_comb begin
      stall_d = stall_q;
      if (busy_i && (stall_q != '1)) begin
         stall_d = stall_q + CNT_W'(1);
      end

      run_d = run_q;
      wd_d  = wd_q;
      if (wd_clear_i) begin
         run_d = RUN_TOP;
         wd_d  = 1'b0;
      end else if (!busy_i) begin
         run_d = RUN_TOP;
      end else if (run_q == '0) begin
         wd_d = 1'b1;
      end else begin
         run_d = run_q - RUN_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_q <= '0;
         run_q   <= RUN_TOP;
         wd_q    <= 1'b0;
      end else begin
         stall_q <= stall_d;
         run_q   <= run_d;
         wd_q    <= wd_d;
      end
   end

   assign stall_cycles_o = stall_q;
   assign watchdog_o     = wd_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: multi-source miss stalling, redirect handshake, wrong-path kill.
//   state     | meaning
//   KILL_IDLE | no wrong-path fetch outstanding
//   KILL_PEND | redirect taken during a fetch; drop that fetch when it lands in R[0]
module pipe_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int                    NSTAGE      = 5,
   parameter int                    NSRC        = 2,
   parameter int                    ST_W        = hazard_pkg::ST_W,
   parameter logic [NSRC*ST_W-1:0]  SRC_STAGE   = SRC_STAGE_DEF,
   parameter int                    REDIR_STAGE = 2,
   parameter int                    CNT_W       = 32,
   parameter int                    TIMEOUT     = 1024
) (
   input  logic               clk,
   input  logic               rstn,
   pipe_hazard_ctrl_if.slave  hz
);

   localparam logic [ST_W-1:0] REDIR_IDX = ST_W'(REDIR_STAGE);

   logic [NSRC-1:0]   busy;
   logic              any_busy;
   logic [ST_W-1:0]   d_stage;
   logic              ack;
   logic              kill_done;
   logic [NSTAGE-1:0] stall_raw, flush_raw;
   kill_state_e       state_q, state_d;

   assign busy     = hz.src_valid & ~hz.src_ready;
   assign any_busy = |busy;

   always_comb begin
      d_stage = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (busy[i] && (SRC_STAGE[i*ST_W +: ST_W] > d_stage)) begin
            d_stage = SRC_STAGE[i*ST_W +: ST_W];
         end
      end
   end

   assign ack = hz.redirect & (~any_busy | (d_stage < REDIR_IDX));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= KILL_IDLE;
      else       state_q <= state_d;
   end

   // A redirect landing while the fetch is still busy (re)arms the kill; completion drops it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         KILL_IDLE: if (ack && busy[SRC_ICACHE])  state_d = KILL_PEND;
         KILL_PEND: if (!busy[SRC_ICACHE])        state_d = KILL_IDLE;
         default:                                 state_d = KILL_IDLE;
      endcase
   end

   always_comb begin
      kill_done = (state_q == KILL_PEND) && !busy[SRC_ICACHE];
      stall_raw = '0;
      flush_raw = '0;
      for (int j = 0; j < NSTAGE; j++) begin
         if (any_busy && (ST_W'(j) < d_stage))  stall_raw[j] = 1'b1;
         if (any_busy && (ST_W'(j) == d_stage)) flush_raw[j] = 1'b1;
         if (ack && (j < REDIR_STAGE))          flush_raw[j] = 1'b1;
      end
      if (kill_done) flush_raw[0] = 1'b1;
   end

   assign hz.redirect_ack = ack;
   assign hz.pc_stall     = any_busy & ~ack;
   assign hz.stage_stall  = stall_raw;
   assign hz.stage_flush  = flush_raw & ~stall_raw;

   hazard_stall_cnt #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) u_stall_cnt (
      .clk            (clk),
      .rstn           (rstn),
      .busy_i         (any_busy),
      .wd_clear_i     (hz.wd_clear),
      .stall_cycles_o (hz.stall_cycles),
      .watchdog_o     (hz.watchdog)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a rule-level model.
module tb_pipe_hazard_ctrl;

   localparam int NSTAGE  = 5;
   localparam int NSRC    = 2;
   localparam int REDIR   = 2;
   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.NSTAGE(NSTAGE), .NSRC(NSRC), .CNT_W(CNT_W)) hz ();

   pipe_hazard_ctrl #(
      .NSTAGE      (NSTAGE),
      .NSRC        (NSRC),
      .ST_W        (3),
      .SRC_STAGE   ({3'd2, 3'd0}),
      .REDIR_STAGE (REDIR),
      .CNT_W       (CNT_W),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .hz   (hz)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // model state (m_*) and its value after the coming edge (n_*)
   bit m_kill, n_kill, m_wd, n_wd;
   int m_cnt, n_cnt, m_run, n_run;
   bit exp_ack;
   logic [16:0] exp_vec;
   logic [16:0] act_vec;

   assign act_vec = {hz.pc_stall, hz.redirect_ack, hz.stage_stall, hz.stage_flush,
                     hz.stall_cycles, hz.watchdog};

   function automatic int src_stage(input int i);
      return (i == 1) ? 2 : 0;
   endfunction

   task automatic step(input logic [1:0] v, input logic [1:0] r, input logic redir, input logic clr);
      int d;
      bit any, busy0;
      logic [NSTAGE-1:0] stl, fl;
      hz.src_valid = v;
      hz.src_ready = r;
      hz.redirect  = redir;
      hz.wd_clear  = clr;
      any = 0;
      d   = 0;
      for (int i = 0; i < NSRC; i++) begin
         if (v[i] && !r[i]) begin
            any = 1;
            if (src_stage(i) > d) d = src_stage(i);
         end
      end
      busy0   = v[0] && !r[0];
      exp_ack = redir && (!any || d < REDIR);
      for (int j = 0; j < NSTAGE; j++) begin
         stl[j] = any && (j < d);
         fl[j]  = (any && j == d) || (exp_ack && j < REDIR) || (j == 0 && m_kill && !busy0);
         if (stl[j]) fl[j] = 1'b0;
      end
      exp_vec = {any && !exp_ack, exp_ack, stl, fl, 4'(m_cnt), m_wd};

      n_kill = m_kill;
      if (exp_ack && busy0)      n_kill = 1;
      else if (m_kill && !busy0) n_kill = 0;
      n_cnt = (any && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
      n_run = m_run;
      n_wd  = m_wd;
      if (clr) begin
         n_wd  = 0;
         n_run = 0;
      end else if (!any) begin
         n_run = 0;
      end else if (m_run == TIMEOUT - 1) begin
         n_wd = 1;
      end else begin
         n_run = m_run + 1;
      end
      #3;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      m_kill = n_kill;
      m_cnt  = n_cnt;
      m_run  = n_run;
      m_wd   = n_wd;
   endtask

   task automatic do_reset(input string tag);
      rstn   = 1'b0;
      m_kill = 0;
      m_cnt  = 0;
      m_run  = 0;
      m_wd   = 0;
      step(hz.src_valid, hz.src_ready, hz.redirect, hz.wd_clear);
      if (act_vec !== exp_vec) begin
         n_fail++;
         $display("FAIL reset_%s: got %b want %b", tag, act_vec, exp_vec);
      end
      n_cmp++;
      @(posedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      hz.src_valid = '0;
      hz.src_ready = '0;
      hz.redirect  = 1'b0;
      hz.wd_clear  = 1'b0;
      do_reset("idle");
      if (act_vec !== 17'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want all zero", act_vec);
      end
      n_cmp++;
   endtask

   task automatic test_icache_miss();
      do_reset("icache");
      for (int k = 0; k < 5; k++) begin
         step((k == 4) ? 2'b00 : 2'b01, (k == 3) ? 2'b01 : 2'b00, 1'b0, 1'b0);
         if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL icache_miss c%0d: got %b want %b", k, act_vec, exp_vec);
         end
         n_cmp++;
         tick();
      end
      if (hz.stall_cycles !== 4'd3) begin
         n_fail++;
         $display("FAIL icache_stall_cycles: got %0d want 3", hz.stall_cycles);
      end
      n_cmp++;
   endtask

   task automatic test_dual_miss();
      do_reset("dual");
      for (int k = 0; k < 4; k++) begin
         step(2'b11, (k == 3) ? 2'b11 : 2'b00, 1'b0, 1'b0);
         if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL dual_miss c%0d: got %b want %b", k, act_vec, exp_vec);
         end
         n_cmp++;
         if (k == 0) begin
            if ({hz.pc_stall, hz.stage_stall, hz.stage_flush} !== {1'b1, 5'b00011, 5'b00100}) begin
               n_fail++;
               $display("FAIL dual_miss_shape: got pc=%b stall=%b flush=%b want pc=1 stall=00011 flush=00100",
                        hz.pc_stall, hz.stage_stall, hz.stage_flush);
            end
            n_cmp++;
         end
         tick();
      end
   endtask

   task automatic test_redirect_dcache();
      do_reset("redir_d");
      for (int k = 0; k < 6; k++) begin
         step((k == 5) ? 2'b00 : 2'b10, (k == 4) ? 2'b10 : 2'b00, (k < 5), 1'b0);
         if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL redirect_dcache c%0d: got %b want %b", k, act_vec, exp_vec);
         end
         n_cmp++;
         if (k < 4 && hz.redirect_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_dcache_early_ack c%0d: got %b want 0", k, hz.redirect_ack);
         end
         if (k < 4) n_cmp++;
         if (k == 4) begin
            if ({hz.redirect_ack, hz.stage_flush, hz.pc_stall} !== {1'b1, 5'b00011, 1'b0}) begin
               n_fail++;
               $display("FAIL redirect_dcache_ack: got ack=%b flush=%b pc=%b want ack=1 flush=00011 pc=0",
                        hz.redirect_ack, hz.stage_flush, hz.pc_stall);
            end
            n_cmp++;
         end
         tick();
      end
   endtask

   task automatic test_redirect_icache();
      logic [1:0] rdy;
      do_reset("redir_i");
      for (int k = 0; k < 5; k++) begin
         rdy = (k >= 3) ? 2'b01 : 2'b00;
         step(2'b01, rdy, (k == 0), 1'b0);
         if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL redirect_icache c%0d: got %b want %b", k, act_vec, exp_vec);
         end
         n_cmp++;
         if (k == 0 && {hz.redirect_ack, hz.stage_flush, hz.pc_stall} !== {1'b1, 5'b00011, 1'b0}) begin
            n_fail++;
            $display("FAIL redirect_icache_ack: got ack=%b flush=%b pc=%b want ack=1 flush=00011 pc=0",
                     hz.redirect_ack, hz.stage_flush, hz.pc_stall);
         end
         if (k == 3 && hz.stage_flush !== 5'b00001) begin
            n_fail++;
            $display("FAIL kill_flush: got %b want 00001", hz.stage_flush);
         end
         if (k == 4 && hz.stage_flush !== 5'b00000) begin
            n_fail++;
            $display("FAIL kill_cleared: got %b want 00000", hz.stage_flush);
         end
         if (k == 0 || k >= 3) n_cmp++;
         tick();
      end
   endtask

   task automatic test_watchdog();
      do_reset("wd");
      for (int k = 0; k < 21; k++) begin
         if (k == 8) step(2'b00, 2'b00, 1'b0, 1'b1);
         else        step(2'b01, 2'b00, 1'b0, (k == 16));
         if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL watchdog c%0d: got %b want %b", k, act_vec, exp_vec);
         end
         n_cmp++;
         tick();
         if (k == 7 && hz.watchdog !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_set: got %b want 1", hz.watchdog);
         end
         if ((k == 8 || k == 16) && hz.watchdog !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_clear c%0d: got %b want 0", k, hz.watchdog);
         end
         if (k == 7 || k == 8 || k == 16) n_cmp++;
      end
      if (hz.stall_cycles !== 4'd15) begin
         n_fail++;
         $display("FAIL stall_saturate: got %0d want 15", hz.stall_cycles);
      end
      n_cmp++;
   endtask

   task automatic test_reset_mid_kill();
      do_reset("pre_kill");
      for (int k = 0; k < 5; k++) begin
         step(2'b01, 2'b00, (k == 0), 1'b0);
         if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL mid_kill_setup c%0d: got %b want %b", k, act_vec, exp_vec);
         end
         n_cmp++;
         tick();
      end
      if (hz.stall_cycles !== 4'd5) begin
         n_fail++;
         $display("FAIL mid_kill_count: got %0d want 5", hz.stall_cycles);
      end
      n_cmp++;
      do_reset("mid_kill");
      if (hz.stall_cycles !== 4'd0 || hz.watchdog !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_kill_reset: got cnt=%0d wd=%b want 0 0", hz.stall_cycles, hz.watchdog);
      end
      n_cmp++;
      step(2'b01, 2'b01, 1'b0, 1'b0);
      if (hz.stage_flush !== 5'b00000 || act_vec !== exp_vec) begin
         n_fail++;
         $display("FAIL mid_kill_no_flush: got %b want %b", act_vec, exp_vec);
      end
      n_cmp++;
      tick();
   endtask

   task automatic test_random();
      logic [1:0] v, r;
      logic redir, held;
      held = 1'b0;
      do_reset("random");
      for (int k = 0; k < 400; k++) begin
         v[0]  = ($urandom_range(0, 4) != 0);
         v[1]  = ($urandom_range(0, 2) == 0);
         r[0]  = ($urandom_range(0, 3) == 0);
         r[1]  = ($urandom_range(0, 3) == 0);
         redir = held | ($urandom_range(0, 3) == 0);
         step(v, r, redir, ($urandom_range(0, 15) == 0));
         if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL random c%0d: got %b want %b", k, act_vec, exp_vec);
         end
         n_cmp++;
         held = redir & ~exp_ack;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_icache_miss();
      test_dual_miss();
      test_redirect_dcache();
      test_redirect_icache();
      test_watchdog();
      test_reset_mid_kill();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
